// File: rtl/hpb_cfg_router.sv
// Host-config buffer and channel router.
// In-order FIFO of host config words; the head word is steered to the
// consumer named by its top CH_W bits. Words naming a channel that does
// not exist are discarded and counted, so they never stall the path.
module hpb_cfg_router #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_config_valid,
    input  logic [DATA_W-1:0]       in_config_data,
    output logic                    in_config_accept,
    output logic [NUM_CH-1:0]       out_config_valid,
    output logic [DATA_W-1:0]       out_config_data,
    input  logic [NUM_CH-1:0]       out_config_accept,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic [15:0]             drop_count
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(DEPTH);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CH_W:0] CH_LIMIT   = (CH_W + 1)'(NUM_CH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              drop_pulse;

    logic [DATA_W-1:0] head;
    logic [CH_W-1:0]   chan;
    logic              non_empty;
    logic              chan_ok;
    logic              push;
    logic              pop;
    logic              drop;

    assign head      = mem[rd_ptr];
    assign chan      = head[DATA_W-1 -: CH_W];
    assign non_empty = (count != '0);
    assign chan_ok   = ({1'b0, chan} < CH_LIMIT);

    assign in_config_accept = !reset && !flush && (count != FULL_COUNT);
    assign push             = in_config_valid && in_config_accept;
    assign drop             = non_empty && !chan_ok;

    assign out_config_data  = head;
    assign fill_level       = count;

    // Steer the head word: one-hot valid for a real channel, pop on its accept
    // or unconditionally when the channel does not exist.
    always_comb begin
        out_config_valid = '0;
        pop              = 1'b0;
        if (non_empty) begin
            if (chan_ok) begin
                out_config_valid[chan] = 1'b1;
                pop                    = out_config_accept[chan];
            end else begin
                pop = 1'b1;
            end
        end
    end

    // Storage write; contents are deliberately left untouched by reset/flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_config_data;
        end
    end

    // Pointer and occupancy tracking with reset over flush priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Drop counter: the pop edge registers a pulse, the counter follows one
    // edge later and saturates; flush leaves the count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            drop_pulse <= drop && !flush;
            if (drop_pulse && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hpb_cfg_router.sv
// Bench for hpb_cfg_router: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_hpb_cfg_router;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int NUM_CH = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_config_valid;
    logic [DATA_W-1:0] in_config_data;
    logic              in_config_accept;
    logic [NUM_CH-1:0] out_config_valid;
    logic [DATA_W-1:0] out_config_data;
    logic [NUM_CH-1:0] out_config_accept;
    logic [2:0]        fill_level;
    logic [15:0]       drop_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] q[$];
    int unsigned m_drop;
    bit          m_pend;

    hpb_cfg_router #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .in_config_valid   (in_config_valid),
        .in_config_data    (in_config_data),
        .in_config_accept  (in_config_accept),
        .out_config_valid  (out_config_valid),
        .out_config_data   (out_config_data),
        .out_config_accept (out_config_accept),
        .fill_level        (fill_level),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_word(input int unsigned ch);
        logic [63:0] w;
        w        = {32'($urandom), 32'($urandom)};
        w[63:62] = 2'(ch);
        return w;
    endfunction

    // Expected outputs from the model for the inputs currently applied.
    task automatic compare_outputs();
        logic [63:0] hd;
        logic [2:0]  v;
        int          ch;
        v  = '0;
        hd = '0;
        if (q.size() > 0) begin
            hd = q[0];
            ch = int'(hd[63:62]);
            if (ch < NUM_CH) v[ch] = 1'b1;
        end
        check_eq("accept", 64'(in_config_accept), 64'(!reset && !flush && (q.size() != DEPTH)));
        check_eq("valid", 64'(out_config_valid), 64'(v));
        if (v != '0) check_eq("data", out_config_data, hd);
        check_eq("fill", 64'(fill_level), 64'(q.size()));
        check_eq("drops", 64'(drop_count), 64'(m_drop));
    endtask

    // Advance the model across one clock edge using the applied inputs.
    task automatic model_edge();
        logic [63:0] hd;
        int          ch;
        bit          do_push, do_pop, do_drop;
        if (reset) begin
            q.delete();
            m_drop = 0;
            m_pend = 0;
            return;
        end
        if (m_pend && m_drop != 32'hFFFF) m_drop++;
        m_pend = 0;
        if (flush) begin
            q.delete();
            return;
        end
        do_push = in_config_valid && (q.size() != DEPTH);
        do_pop  = 0;
        do_drop = 0;
        if (q.size() > 0) begin
            hd = q[0];
            ch = int'(hd[63:62]);
            if (ch >= NUM_CH) begin
                do_pop  = 1;
                do_drop = 1;
            end else begin
                do_pop = out_config_accept[ch];
            end
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(in_config_data);
        m_pend = do_drop;
    endtask

    task automatic step(input bit rst, input bit fl, input bit v,
                        input logic [63:0] d, input logic [2:0] acc);
        reset             = rst;
        flush             = fl;
        in_config_valid   = v;
        in_config_data    = d;
        out_config_accept = acc;
        #1;
        compare_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        reset             = 1'b1;
        flush             = 1'b0;
        in_config_valid   = 1'b0;
        in_config_data    = '0;
        out_config_accept = '0;
        m_drop            = 0;
        m_pend            = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state checked while reset is held
        step(1, 0, 0, '0, 3'b000);

        // Single word to channel 0
        step(0, 0, 1, 64'h0000_0000_0000_00A1, 3'b111);
        step(0, 0, 0, '0, 3'b111);
        step(0, 0, 0, '0, 3'b111);

        // Five back-to-back pushes into a stalled channel
        for (int i = 0; i < 5; i++) step(0, 0, 1, mk_word(0), 3'b000);
        check_eq("fill_full", 64'(fill_level), 64'd4);
        step(0, 0, 0, '0, 3'b001);
        step(0, 0, 0, '0, 3'b000);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 3'b111);

        // chan 1, bad chan 3, chan 2
        step(0, 0, 1, mk_word(1), 3'b111);
        step(0, 0, 1, mk_word(3), 3'b111);
        step(0, 0, 1, mk_word(2), 3'b111);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 3'b111);
        check_eq("drop_one", 64'(drop_count), 64'd1);

        // Head-of-line blocking behind stalled channel 2
        step(0, 0, 1, mk_word(2), 3'b011);
        step(0, 0, 1, mk_word(0), 3'b011);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 3'b011);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 3'b100);
        step(0, 0, 0, '0, 3'b111);

        // Flush with a push offered in the same cycle
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk_word(1), 3'b000);
        step(0, 1, 1, mk_word(1), 3'b000);
        step(0, 0, 0, '0, 3'b000);
        step(0, 0, 0, '0, 3'b000);

        // Drop counter saturation
        for (int i = 0; i < 65540; i++) step(0, 0, 1, mk_word(3), 3'b000);
        step(0, 0, 0, '0, 3'b000);
        step(0, 0, 0, '0, 3'b000);
        check_eq("drop_sat", 64'(drop_count), 64'hFFFF);

        // Reset mid-stream with two words held
        step(0, 0, 1, mk_word(0), 3'b000);
        step(0, 0, 1, mk_word(1), 3'b000);
        step(1, 0, 1, mk_word(2), 3'b000);
        step(0, 0, 0, '0, 3'b000);
        step(0, 0, 0, '0, 3'b000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0,
                 mk_word($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
